// File: rtl/dmac_slave_mc_if.sv
// Bus slave port of the multi-channel DMAC register file.
// Transfer rule: an access happens on every rising clk edge where S_sel is
// high; S_wr selects write (S_din captured at that edge) or read (S_dout
// carries the data from that edge on, for one cycle). There is no wait state
// and no back-pressure: the slave accepts one access per cycle.
interface dmac_slave_mc_if #(
    parameter int DATA_W = 32
);
    logic              S_sel;
    logic              S_wr;
    logic [7:0]        S_address;
    logic [DATA_W-1:0] S_din;
    logic [DATA_W-1:0] S_dout;

    modport master (
        output S_sel,
        output S_wr,
        output S_address,
        output S_din,
        input  S_dout
    );

    modport slave (
        input  S_sel,
        input  S_wr,
        input  S_address,
        input  S_din,
        output S_dout
    );
endinterface

// File: rtl/dmac_slave_mc.sv
// Multi-channel DMAC slave register file. One register bank per channel
// (start/clear/mode/address/size, descriptor counter, sticky W1C interrupt
// status) and a single registered, OR-reduced interrupt line.
module dmac_slave_mc #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 32,
    parameter int DESC_W = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    dmac_slave_mc_if.slave           bus,
    output logic                     interrupt,
    input  logic [NUM_CH-1:0]        op_done,
    input  logic [NUM_CH-1:0]        desc_pop,
    output logic [NUM_CH-1:0]        op_start,
    output logic [NUM_CH-1:0]        op_clear,
    output logic [NUM_CH*3-1:0]      op_mode,
    output logic [NUM_CH-1:0]        wr_en,
    output logic [NUM_CH*DATA_W-1:0] src_addr,
    output logic [NUM_CH*DATA_W-1:0] dest_addr,
    output logic [NUM_CH*DATA_W-1:0] data_size,
    output logic [NUM_CH*DESC_W-1:0] descriptor_size
);
    localparam logic [DESC_W-1:0] DESC_MAX = {DESC_W{1'b1}};
    localparam logic [3:0]        NUM_CH_L = 4'(NUM_CH);

    localparam logic [3:0] OFF_CLEAR  = 4'h0;
    localparam logic [3:0] OFF_START  = 4'h1;
    localparam logic [3:0] OFF_INT_EN = 4'h2;
    localparam logic [3:0] OFF_SRC    = 4'h3;
    localparam logic [3:0] OFF_DEST   = 4'h4;
    localparam logic [3:0] OFF_PUSH   = 4'h5;
    localparam logic [3:0] OFF_DESC   = 4'h6;
    localparam logic [3:0] OFF_SIZE   = 4'h7;
    localparam logic [3:0] OFF_MODE   = 4'h8;
    localparam logic [3:0] OFF_DONE   = 4'h9;
    localparam logic [3:0] OFF_STATUS = 4'hA;

    // Decoded access
    logic [2:0]        acc_ch;
    logic [3:0]        acc_off;
    logic              acc_hit;
    logic              wr_hit;
    logic              rd_hit;

    // Per-channel bank state
    logic [NUM_CH-1:0] clr_q;
    logic [NUM_CH-1:0] start_q;
    logic [NUM_CH-1:0] int_en_q;
    logic [NUM_CH-1:0] done_q;
    logic [NUM_CH-1:0] wr_en_q;
    logic [2:0]        mode_q [NUM_CH];
    logic [DATA_W-1:0] src_q  [NUM_CH];
    logic [DATA_W-1:0] dest_q [NUM_CH];
    logic [DATA_W-1:0] size_q [NUM_CH];
    logic [DESC_W-1:0] cnt_q  [NUM_CH];
    logic [1:0]        stat_q [NUM_CH];

    // Per-channel next-state helpers
    logic [NUM_CH-1:0] bank_we;
    logic [NUM_CH-1:0] push_req;
    logic [NUM_CH-1:0] done_rise;
    logic [NUM_CH-1:0] ovf_set;
    logic [NUM_CH-1:0] int_pending;
    logic [1:0]        w1c_mask [NUM_CH];
    logic [DATA_W-1:0] rd_data;

    // Address decode: bit 7 set, a missing channel or an unused offset all miss.
    always_comb begin
        acc_ch  = bus.S_address[6:4];
        acc_off = bus.S_address[3:0];
        acc_hit = !bus.S_address[7] && ({1'b0, acc_ch} < NUM_CH_L) && (acc_off <= OFF_STATUS);
        wr_hit  = bus.S_sel && bus.S_wr && acc_hit;
        rd_hit  = bus.S_sel && !bus.S_wr && acc_hit;
    end

    // Per-channel write enables, push/overflow qualification and done-edge detect.
    always_comb begin
        bank_we     = '0;
        push_req    = '0;
        done_rise   = '0;
        ovf_set     = '0;
        int_pending = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            bank_we[c]     = wr_hit && (acc_ch == 3'(c));
            push_req[c]    = bank_we[c] && (acc_off == OFF_PUSH) && bus.S_din[0];
            done_rise[c]   = op_done[c] && !done_q[c];
            // Push+pop at full is a net no-op on the count, so it is not an overflow.
            ovf_set[c]     = push_req[c] && !desc_pop[c] && (cnt_q[c] == DESC_MAX);
            w1c_mask[c]    = (bank_we[c] && (acc_off == OFF_STATUS)) ? bus.S_din[1:0] : 2'b00;
            int_pending[c] = int_en_q[c] && (|stat_q[c]);
        end
    end

    // Read mux over the addressed bank; write-only and missing registers read 0.
    always_comb begin
        rd_data = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (acc_ch == 3'(c)) begin
                case (acc_off)
                    OFF_CLEAR:  rd_data = {{(DATA_W-1){1'b0}}, clr_q[c]};
                    OFF_START:  rd_data = {{(DATA_W-1){1'b0}}, start_q[c]};
                    OFF_INT_EN: rd_data = {{(DATA_W-1){1'b0}}, int_en_q[c]};
                    OFF_SRC:    rd_data = src_q[c];
                    OFF_DEST:   rd_data = dest_q[c];
                    OFF_DESC:   rd_data = {{(DATA_W-DESC_W){1'b0}}, cnt_q[c]};
                    OFF_SIZE:   rd_data = size_q[c];
                    OFF_MODE:   rd_data = {{(DATA_W-3){1'b0}}, mode_q[c]};
                    OFF_DONE:   rd_data = {{(DATA_W-1){1'b0}}, done_q[c]};
                    OFF_STATUS: rd_data = {{(DATA_W-2){1'b0}}, stat_q[c]};
                    default:    rd_data = '0;
                endcase
            end
        end
    end

    // Register banks: bus writes, descriptor counting, sticky status and channel clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                clr_q[c]    <= 1'b0;
                start_q[c]  <= 1'b0;
                int_en_q[c] <= 1'b0;
                done_q[c]   <= 1'b0;
                wr_en_q[c]  <= 1'b0;
                mode_q[c]   <= '0;
                src_q[c]    <= '0;
                dest_q[c]   <= '0;
                size_q[c]   <= '0;
                cnt_q[c]    <= '0;
                stat_q[c]   <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                // The done sample is a mirror of the input and keeps tracking through
                // a clear, so a clear with op_done held high does not fake a new edge.
                done_q[c] <= op_done[c];
                if (op_clear[c]) begin
                    clr_q[c]    <= 1'b0;
                    start_q[c]  <= 1'b0;
                    int_en_q[c] <= 1'b0;
                    wr_en_q[c]  <= 1'b0;
                    mode_q[c]   <= '0;
                    src_q[c]    <= '0;
                    dest_q[c]   <= '0;
                    size_q[c]   <= '0;
                    cnt_q[c]    <= '0;
                    stat_q[c]   <= '0;
                end else begin
                    wr_en_q[c] <= 1'b0;
                    if (bank_we[c]) begin
                        case (acc_off)
                            OFF_CLEAR:  clr_q[c]    <= bus.S_din[0];
                            OFF_START:  start_q[c]  <= bus.S_din[0];
                            OFF_INT_EN: int_en_q[c] <= bus.S_din[0];
                            OFF_SRC:    src_q[c]    <= bus.S_din;
                            OFF_DEST:   dest_q[c]   <= bus.S_din;
                            OFF_SIZE:   size_q[c]   <= bus.S_din;
                            OFF_MODE:   mode_q[c]   <= bus.S_din[2:0];
                            default:    ;
                        endcase
                    end
                    if (push_req[c] && desc_pop[c]) begin
                        wr_en_q[c] <= 1'b1;
                    end else if (push_req[c]) begin
                        if (cnt_q[c] != DESC_MAX) begin
                            cnt_q[c]   <= cnt_q[c] + 1'b1;
                            wr_en_q[c] <= 1'b1;
                        end
                    end else if (desc_pop[c] && (cnt_q[c] != '0)) begin
                        cnt_q[c] <= cnt_q[c] - 1'b1;
                    end
                    // Hardware set wins over a same-cycle W1C.
                    stat_q[c] <= (stat_q[c] & ~w1c_mask[c]) | {ovf_set[c], done_rise[c]};
                end
            end
        end
    end

    // Registered read data; idle or missed cycles return 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.S_dout <= '0;
        end else begin
            bus.S_dout <= rd_hit ? rd_data : '0;
        end
    end

    // Registered OR of all channel interrupt requests.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            interrupt <= 1'b0;
        end else begin
            interrupt <= |int_pending;
        end
    end

    assign op_start = start_q;
    assign op_clear = clr_q & op_done;
    assign wr_en    = wr_en_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_out
        assign op_mode[3*c +: 3]                  = mode_q[c];
        assign src_addr[c*DATA_W +: DATA_W]       = src_q[c];
        assign dest_addr[c*DATA_W +: DATA_W]      = dest_q[c];
        assign data_size[c*DATA_W +: DATA_W]      = size_q[c];
        assign descriptor_size[c*DESC_W +: DESC_W] = cnt_q[c];
    end
endmodule

// File: tb/tb_dmac_slave_mc.sv
// Self-checking bench for the multi-channel DMAC slave register file.
module tb_dmac_slave_mc;
    localparam int NUM_CH = 2;
    localparam int DATA_W = 32;
    localparam int DESC_W = 4;
    localparam int DMAX   = 15;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    dmac_slave_mc_if #(.DATA_W(DATA_W)) bus ();

    logic [NUM_CH-1:0]        op_done;
    logic [NUM_CH-1:0]        desc_pop;
    logic                     interrupt;
    logic [NUM_CH-1:0]        op_start;
    logic [NUM_CH-1:0]        op_clear;
    logic [NUM_CH*3-1:0]      op_mode;
    logic [NUM_CH-1:0]        wr_en;
    logic [NUM_CH*DATA_W-1:0] src_addr;
    logic [NUM_CH*DATA_W-1:0] dest_addr;
    logic [NUM_CH*DATA_W-1:0] data_size;
    logic [NUM_CH*DESC_W-1:0] descriptor_size;

    dmac_slave_mc #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DESC_W(DESC_W)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .bus             (bus),
        .interrupt       (interrupt),
        .op_done         (op_done),
        .desc_pop        (desc_pop),
        .op_start        (op_start),
        .op_clear        (op_clear),
        .op_mode         (op_mode),
        .wr_en           (wr_en),
        .src_addr        (src_addr),
        .dest_addr       (dest_addr),
        .data_size       (data_size),
        .descriptor_size (descriptor_size)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int wr_pulses [NUM_CH] = '{default: 0};
    logic [DATA_W-1:0] rd;

    // Count descriptor push strobes, sampled mid-cycle.
    always @(negedge clk) begin
        if (reset_n) begin
            for (int c = 0; c < NUM_CH; c++) if (wr_en[c] === 1'b1) wr_pulses[c]++;
        end
    end

    // ---------------- helpers / driver tasks ----------------
    function automatic logic [7:0] adr(int ch, int off);
        return {1'b0, 3'(ch), 4'(off)};
    endfunction
    function automatic logic [DATA_W-1:0] src_of(int c);  return src_addr[c*DATA_W +: DATA_W];  endfunction
    function automatic logic [DATA_W-1:0] dest_of(int c); return dest_addr[c*DATA_W +: DATA_W]; endfunction
    function automatic logic [DATA_W-1:0] size_of(int c); return data_size[c*DATA_W +: DATA_W]; endfunction
    function automatic logic [DESC_W-1:0] cnt_of(int c);  return descriptor_size[c*DESC_W +: DESC_W]; endfunction
    function automatic logic [2:0]        mode_of(int c); return op_mode[3*c +: 3]; endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [DATA_W-1:0] d);
        bus.S_sel = 1'b1; bus.S_wr = 1'b1; bus.S_address = a; bus.S_din = d;
        tick();
        bus.S_sel = 1'b0; bus.S_wr = 1'b0; bus.S_din = '0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [DATA_W-1:0] d);
        bus.S_sel = 1'b1; bus.S_wr = 1'b0; bus.S_address = a;
        tick();
        d = bus.S_dout;
        bus.S_sel = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) tick();
        n_checks++; if (bus.S_dout !== '0) $display("FAIL reset_dout: got %h want 0", bus.S_dout); else n_pass++;
        n_checks++; if (interrupt !== 1'b0) $display("FAIL reset_irq: got %b want 0", interrupt); else n_pass++;
        n_checks++; if (wr_en !== '0) $display("FAIL reset_wr_en: got %b want 0", wr_en); else n_pass++;
        n_checks++; if (descriptor_size !== '0) $display("FAIL reset_desc: got %h want 0", descriptor_size); else n_pass++;
        reset_n = 1'b1;
        tick();
        bus_read(adr(1, 3), rd);
        n_checks++; if (rd !== '0) $display("FAIL reset_read_src1: got %h want 0", rd); else n_pass++;
    endtask

    task automatic test_src_readback();
        bus_write(adr(1, 3), 32'h1000_0040);
        bus_read(adr(1, 3), rd);
        n_checks++; if (rd !== 32'h1000_0040) $display("FAIL src1_read: got %h want 10000040", rd); else n_pass++;
        tick();
        n_checks++; if (bus.S_dout !== '0) $display("FAIL idle_dout: got %h want 0", bus.S_dout); else n_pass++;
        n_checks++; if (src_of(1) !== 32'h1000_0040) $display("FAIL src1_out: got %h want 10000040", src_of(1)); else n_pass++;
        n_checks++; if (src_of(0) !== '0) $display("FAIL src0_untouched: got %h want 0", src_of(0)); else n_pass++;
        bus_read(adr(0, 3), rd);
        n_checks++; if (rd !== '0) $display("FAIL src0_read: got %h want 0", rd); else n_pass++;
    endtask

    task automatic test_push_overflow();
        int base;
        base = wr_pulses[0];
        for (int i = 0; i < 16; i++) bus_write(adr(0, 5), 32'h1);
        tick();
        n_checks++; if (wr_pulses[0] - base !== DMAX) $display("FAIL push_pulses: got %0d want %0d", wr_pulses[0] - base, DMAX); else n_pass++;
        n_checks++; if (cnt_of(0) !== 4'(DMAX)) $display("FAIL push_count: got %0d want %0d", cnt_of(0), DMAX); else n_pass++;
        bus_read(adr(0, 10), rd);
        n_checks++; if (rd !== 32'h2) $display("FAIL ovf_status: got %h want 2", rd); else n_pass++;
        bus_write(adr(0, 2), 32'h1);
        n_checks++; if (interrupt !== 1'b0) $display("FAIL ovf_irq_early: got %b want 0", interrupt); else n_pass++;
        tick();
        n_checks++; if (interrupt !== 1'b1) $display("FAIL ovf_irq: got %b want 1", interrupt); else n_pass++;
        bus_write(adr(0, 10), 32'h2);
        tick();
        n_checks++; if (interrupt !== 1'b0) $display("FAIL ovf_irq_cleared: got %b want 0", interrupt); else n_pass++;
    endtask

    task automatic test_push_pop();
        desc_pop[0] = 1'b1;
        repeat (12) tick();
        desc_pop[0] = 1'b0;
        n_checks++; if (cnt_of(0) !== 4'd3) $display("FAIL pop_to_3: got %0d want 3", cnt_of(0)); else n_pass++;
        desc_pop[0] = 1'b1;
        bus_write(adr(0, 5), 32'h1);
        desc_pop[0] = 1'b0;
        n_checks++; if (wr_en[0] !== 1'b1) $display("FAIL pushpop_wr_en: got %b want 1", wr_en[0]); else n_pass++;
        n_checks++; if (cnt_of(0) !== 4'd3) $display("FAIL pushpop_count: got %0d want 3", cnt_of(0)); else n_pass++;
        desc_pop[0] = 1'b1;
        repeat (4) tick();
        desc_pop[0] = 1'b0;
        n_checks++; if (cnt_of(0) !== 4'd0) $display("FAIL pop_at_zero: got %0d want 0", cnt_of(0)); else n_pass++;
    endtask

    task automatic test_done_irq();
        repeat (2) tick();
        op_done[0] = 1'b1;
        tick();
        n_checks++; if (interrupt !== 1'b0) $display("FAIL done_irq_1cyc: got %b want 0", interrupt); else n_pass++;
        tick();
        n_checks++; if (interrupt !== 1'b1) $display("FAIL done_irq_2cyc: got %b want 1", interrupt); else n_pass++;
        bus_read(adr(0, 9), rd);
        n_checks++; if (rd !== 32'h1) $display("FAIL op_done_reg: got %h want 1", rd); else n_pass++;
        bus_write(adr(0, 10), 32'h1);
        tick();
        n_checks++; if (interrupt !== 1'b0) $display("FAIL w1c_irq: got %b want 0", interrupt); else n_pass++;
        bus_read(adr(0, 10), rd);
        n_checks++; if (rd !== '0) $display("FAIL w1c_no_reset: got %h want 0", rd); else n_pass++;
        op_done[0] = 1'b0;
        tick();
        op_done[0] = 1'b1;
        bus_write(adr(0, 10), 32'h1);
        bus_read(adr(0, 10), rd);
        n_checks++; if (rd !== 32'h1) $display("FAIL set_beats_w1c: got %h want 1", rd); else n_pass++;
        bus_write(adr(0, 2), 32'h0);
        bus_write(adr(0, 10), 32'h3);
        op_done[0] = 1'b0;
        tick();
    endtask

    task automatic test_clear();
        bus_write(adr(1, 3), 32'h1111_2222);
        bus_write(adr(1, 4), 32'h3333_4444);
        bus_write(adr(1, 7), 32'h0000_0100);
        bus_write(adr(1, 8), 32'h5);
        bus_write(adr(1, 1), 32'h1);
        bus_write(adr(1, 2), 32'h1);
        bus_write(adr(0, 3), 32'hA5A5_0000);
        bus_write(adr(0, 7), 32'h0000_0200);
        bus_write(adr(1, 5), 32'h1);
        bus_write(adr(1, 5), 32'h1);
        n_checks++; if (op_start[1] !== 1'b1) $display("FAIL start1: got %b want 1", op_start[1]); else n_pass++;
        n_checks++; if (mode_of(1) !== 3'd5) $display("FAIL mode1: got %0d want 5", mode_of(1)); else n_pass++;
        n_checks++; if (cnt_of(1) !== 4'd2) $display("FAIL cnt1: got %0d want 2", cnt_of(1)); else n_pass++;
        op_done[1] = 1'b1;
        tick();
        bus_write(adr(1, 0), 32'h1);
        n_checks++; if (op_clear[1] !== 1'b1) $display("FAIL op_clear_out: got %b want 1", op_clear[1]); else n_pass++;
        bus_write(adr(1, 4), 32'h55);
        n_checks++; if (src_of(1) !== '0) $display("FAIL clr_src1: got %h want 0", src_of(1)); else n_pass++;
        n_checks++; if (dest_of(1) !== '0) $display("FAIL clr_dest1_dropped: got %h want 0", dest_of(1)); else n_pass++;
        n_checks++; if (size_of(1) !== '0) $display("FAIL clr_size1: got %h want 0", size_of(1)); else n_pass++;
        n_checks++; if (cnt_of(1) !== '0) $display("FAIL clr_cnt1: got %0d want 0", cnt_of(1)); else n_pass++;
        n_checks++; if (mode_of(1) !== '0) $display("FAIL clr_mode1: got %0d want 0", mode_of(1)); else n_pass++;
        n_checks++; if ({op_start[1], op_clear[1]} !== 2'b00) $display("FAIL clr_start_clear1: got %b want 00", {op_start[1], op_clear[1]}); else n_pass++;
        bus_read(adr(1, 10), rd);
        n_checks++; if (rd !== '0) $display("FAIL clr_status1: got %h want 0", rd); else n_pass++;
        bus_read(adr(1, 2), rd);
        n_checks++; if (rd !== '0) $display("FAIL clr_int_en1: got %h want 0", rd); else n_pass++;
        n_checks++; if (src_of(0) !== 32'hA5A5_0000) $display("FAIL keep_src0: got %h want a5a50000", src_of(0)); else n_pass++;
        n_checks++; if (size_of(0) !== 32'h200) $display("FAIL keep_size0: got %h want 200", size_of(0)); else n_pass++;
        op_done[1] = 1'b0;
        tick();
    endtask

    task automatic test_invalid();
        bus_write(8'h23, 32'hDEAD_BEEF);
        bus_write(8'h83, 32'hCAFE_F00D);
        bus_write(8'h0B, 32'h1234_5678);
        n_checks++; if (src_of(0) !== 32'hA5A5_0000) $display("FAIL inv_src0: got %h want a5a50000", src_of(0)); else n_pass++;
        n_checks++; if (src_of(1) !== '0) $display("FAIL inv_src1: got %h want 0", src_of(1)); else n_pass++;
        bus_read(8'h83, rd);
        n_checks++; if (rd !== '0) $display("FAIL inv_read_bit7: got %h want 0", rd); else n_pass++;
        bus_read(8'h23, rd);
        n_checks++; if (rd !== '0) $display("FAIL inv_read_ch2: got %h want 0", rd); else n_pass++;
        bus_read(8'h0B, rd);
        n_checks++; if (rd !== '0) $display("FAIL inv_read_offB: got %h want 0", rd); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bus_write(adr(0, 5), 32'h1);
        n_checks++; if (wr_en[0] !== 1'b1) $display("FAIL mid_push: got %b want 1", wr_en[0]); else n_pass++;
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (wr_en !== '0) $display("FAIL mid_wr_en: got %b want 0", wr_en); else n_pass++;
        n_checks++; if (src_addr !== '0) $display("FAIL mid_src: got %h want 0", src_addr); else n_pass++;
        n_checks++; if (cnt_of(0) !== '0) $display("FAIL mid_cnt: got %0d want 0", cnt_of(0)); else n_pass++;
        tick();
        n_checks++; if (wr_en !== '0) $display("FAIL mid_wr_en_held: got %b want 0", wr_en); else n_pass++;
        reset_n = 1'b1;
        tick();
    endtask

    // Randomized register/descriptor traffic against a value-level model.
    task automatic test_random();
        logic [DATA_W-1:0] model [NUM_CH][16];
        int cnt [NUM_CH];
        int exp_pulses [NUM_CH];
        int base [NUM_CH];
        logic [DATA_W-1:0] exp_q [$];
        int wr_offs [5] = '{1, 3, 4, 7, 8};
        int rd_offs [7] = '{1, 3, 4, 5, 6, 7, 8};
        int ch, op, off;
        logic [DATA_W-1:0] d;
        logic exp_wr;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int o = 0; o < 16; o++) model[c][o] = '0;
            cnt[c] = 0; exp_pulses[c] = 0; base[c] = wr_pulses[c];
        end
        for (int it = 0; it < 300; it++) begin
            ch = int'($urandom_range(0, NUM_CH - 1));
            op = int'($urandom_range(0, 4));
            case (op)
                0: begin
                    off = wr_offs[$urandom_range(0, 4)];
                    d = $urandom;
                    bus_write(adr(ch, off), d);
                    model[ch][off] = (off == 1) ? (d & 32'h1) : (off == 8) ? (d & 32'h7) : d;
                end
                1: begin
                    off = rd_offs[$urandom_range(0, 6)];
                    exp_q.push_back((off == 5) ? '0 : (off == 6) ? DATA_W'(cnt[ch]) : model[ch][off]);
                    bus_read(adr(ch, off), rd);
                    d = exp_q.pop_front();
                    n_checks++; if (rd !== d) $display("FAIL rnd_read ch%0d off%0d: got %h want %h", ch, off, rd, d); else n_pass++;
                end
                2, 3: begin
                    if (op == 3) begin
                        desc_pop[ch] = 1'b1;
                        exp_wr = 1'b1;
                    end else if (cnt[ch] < DMAX) begin
                        cnt[ch]++;
                        exp_wr = 1'b1;
                    end else begin
                        exp_wr = 1'b0;
                    end
                    if (exp_wr) exp_pulses[ch]++;
                    bus_write(adr(ch, 5), 32'h1);
                    desc_pop[ch] = 1'b0;
                    n_checks++; if (wr_en[ch] !== exp_wr) $display("FAIL rnd_wr_en ch%0d: got %b want %b", ch, wr_en[ch], exp_wr); else n_pass++;
                end
                default: begin
                    if (cnt[ch] > 0) cnt[ch]--;
                    desc_pop[ch] = 1'b1;
                    tick();
                    desc_pop[ch] = 1'b0;
                end
            endcase
            n_checks++; if (cnt_of(ch) !== DESC_W'(cnt[ch])) $display("FAIL rnd_count ch%0d: got %0d want %0d", ch, cnt_of(ch), cnt[ch]); else n_pass++;
        end
        tick();
        for (int c = 0; c < NUM_CH; c++) begin
            n_checks++; if (wr_pulses[c] - base[c] !== exp_pulses[c]) $display("FAIL rnd_pulses ch%0d: got %0d want %0d", c, wr_pulses[c] - base[c], exp_pulses[c]); else n_pass++;
            n_checks++; if (src_of(c) !== model[c][3]) $display("FAIL rnd_src ch%0d: got %h want %h", c, src_of(c), model[c][3]); else n_pass++;
            n_checks++; if (mode_of(c) !== model[c][8][2:0]) $display("FAIL rnd_mode ch%0d: got %0d want %0d", c, mode_of(c), model[c][8][2:0]); else n_pass++;
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        bus.S_sel = 1'b0; bus.S_wr = 1'b0; bus.S_address = '0; bus.S_din = '0;
        op_done = '0; desc_pop = '0;
        test_reset();
        test_src_readback();
        test_push_overflow();
        test_push_pop();
        test_done_irq();
        test_clear();
        test_invalid();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard time limit so a stuck run still ends.
    initial begin
        #2000000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end
endmodule
